hex_display_scheduler: RTL and testbench

//  Avalon-MM master that drives a bank of 7-bit seven-segment output PIOs (one per HEX digit).

---
 rtl/hex_display_scheduler.sv | 161 ++++++++++++++++
 tb/tb_hex_display_scheduler.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hex_display_scheduler
// Purpose  : Avalon-MM master that writes changed seven-segment patterns to HEX PIOs
// Revision : 1.0 - initial release
// ============================================================================
module hex_display_scheduler #(
    parameter int NUM_DIGITS = 6,
    parameter int IDX_W      = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic                    value_valid,
    output logic                    value_ready,
    input  logic                    refresh,
    output logic [IDX_W-1:0]        avm_address,
    output logic                    avm_write,
    output logic [31:0]             avm_writedata,
    input  logic                    avm_waitrequest,
    output logic                    busy
);

    localparam logic [6:0]       c_SEG_BLANK = 7'h7F;
    localparam logic [IDX_W-1:0] c_LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE   = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_WRITE = 2'd2
    } state_t;

    state_t                         r_state_q, w_state_d;
    logic [4*NUM_DIGITS-1:0]        r_value_q, w_value_d;
    logic [NUM_DIGITS-1:0]          r_mask_q, w_mask_d;
    logic [IDX_W-1:0]               r_idx_q, w_idx_d;
    logic [NUM_DIGITS-1:0][6:0]     r_shadow_q, w_shadow_d;
    logic [NUM_DIGITS-1:0]          r_shadow_valid_q, w_shadow_valid_d;
    logic                           r_avm_write_q, w_avm_write_d;
    logic [IDX_W-1:0]               r_avm_address_q, w_avm_address_d;
    logic [31:0]                    r_avm_writedata_q, w_avm_writedata_d;

    logic [6:0]                     w_pat;
    logic                           w_last;

    // Active-low segments, bit0 = a ... bit6 = g
    function automatic logic [6:0] enc7(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    always_comb begin
        w_state_d         = r_state_q;
        w_value_d         = r_value_q;
        w_mask_d          = r_mask_q;
        w_idx_d           = r_idx_q;
        w_shadow_d        = r_shadow_q;
        w_shadow_valid_d  = refresh ? '0 : r_shadow_valid_q;
        w_avm_write_d     = r_avm_write_q;
        w_avm_address_d   = r_avm_address_q;
        w_avm_writedata_d = r_avm_writedata_q;

        w_pat  = r_mask_q[r_idx_q] ? c_SEG_BLANK : enc7(r_value_q[{r_idx_q, 2'b00} +: 4]);
        w_last = (r_idx_q == c_LAST_IDX);

        unique case (r_state_q)
            S_IDLE: begin
                if (value_valid) begin
                    w_value_d = value_in;
                    w_mask_d  = blank_mask;
                    w_idx_d   = '0;
                    w_state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (r_shadow_valid_q[r_idx_q] && (r_shadow_q[r_idx_q] == w_pat)) begin
                    if (w_last) begin
                        w_state_d = S_IDLE;
                    end else begin
                        w_idx_d = r_idx_q + c_IDX_ONE;
                    end
                end else begin
                    w_avm_write_d     = 1'b1;
                    w_avm_address_d   = r_idx_q;
                    w_avm_writedata_d = {25'b0, w_pat};
                    w_state_d         = S_WRITE;
                end
            end
            S_WRITE: begin
                // Completion sets its own valid bit even if refresh cleared the rest
                if (!avm_waitrequest) begin
                    w_shadow_d[r_idx_q]       = r_avm_writedata_q[6:0];
                    w_shadow_valid_d[r_idx_q] = 1'b1;
                    w_avm_write_d             = 1'b0;
                    if (w_last) begin
                        w_state_d = S_IDLE;
                    end else begin
                        w_idx_d   = r_idx_q + c_IDX_ONE;
                        w_state_d = S_SCAN;
                    end
                end
            end
            default: begin
                w_state_d     = S_IDLE;
                w_avm_write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q         <= S_IDLE;
            r_value_q         <= '0;
            r_mask_q          <= '0;
            r_idx_q           <= '0;
            r_shadow_q        <= '0;
            r_shadow_valid_q  <= '0;
            r_avm_write_q     <= 1'b0;
            r_avm_address_q   <= '0;
            r_avm_writedata_q <= '0;
        end else begin
            r_state_q         <= w_state_d;
            r_value_q         <= w_value_d;
            r_mask_q          <= w_mask_d;
            r_idx_q           <= w_idx_d;
            r_shadow_q        <= w_shadow_d;
            r_shadow_valid_q  <= w_shadow_valid_d;
            r_avm_write_q     <= w_avm_write_d;
            r_avm_address_q   <= w_avm_address_d;
            r_avm_writedata_q <= w_avm_writedata_d;
        end
    end

    assign value_ready   = (r_state_q == S_IDLE);
    assign busy          = ~value_ready;
    assign avm_write     = r_avm_write_q;
    assign avm_address   = r_avm_address_q;
    assign avm_writedata = r_avm_writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_hex_display_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_hex_display_scheduler
// Purpose  : Directed scoreboard bench for hex_display_scheduler
// Revision : 1.0 - initial release
// ============================================================================
module tb_hex_display_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] value_in;
    logic [5:0]  blank_mask;
    logic        value_valid;
    logic        value_ready;
    logic        refresh;
    logic [2:0]  avm_address;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest = 1'b0;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [34:0] exp_q[$];

    int stall_addr = -1;
    int stall_len  = 0;
    int stall_cnt  = 0;

    logic        prev_pend = 1'b0;
    logic [2:0]  prev_addr = '0;
    logic [31:0] prev_data = '0;

    hex_display_scheduler #(.NUM_DIGITS(6), .IDX_W(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .value_in        (value_in),
        .blank_mask      (blank_mask),
        .value_valid     (value_valid),
        .value_ready     (value_ready),
        .refresh         (refresh),
        .avm_address     (avm_address),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // Slave model: stalls the chosen address for stall_len cycles
    always @(posedge clk) begin
        #1;
        if (avm_write && stall_addr >= 0 && int'(avm_address) == stall_addr && stall_cnt < stall_len) begin
            avm_waitrequest = 1'b1;
            stall_cnt++;
        end else begin
            avm_waitrequest = 1'b0;
        end
    end

    // Monitor: pops an expected write on every completed transfer
    always @(negedge clk) begin
        if (reset) begin
            prev_pend = 1'b0;
        end else begin
            if (avm_write) begin
                checks++;
                if (value_ready) begin
                    errors++;
                    $display("FAIL write_while_idle actual ready=%0b required ready=0", value_ready);
                end
            end
            if (prev_pend) begin
                checks++;
                if (!(avm_write && avm_address == prev_addr && avm_writedata == prev_data)) begin
                    errors++;
                    $display("FAIL stall_hold actual wr=%0b addr=%0d data=%0h required wr=1 addr=%0d data=%0h",
                             avm_write, avm_address, avm_writedata, prev_addr, prev_data);
                end
            end
            if (avm_write && !avm_waitrequest) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write actual addr=%0d data=%0h required none", avm_address, avm_writedata);
                end else begin
                    logic [34:0] e;
                    e = exp_q.pop_front();
                    if ({avm_address, avm_writedata} !== e) begin
                        errors++;
                        $display("FAIL write_data actual addr=%0d data=%0h required addr=%0d data=%0h",
                                 avm_address, avm_writedata, e[34:32], e[31:0]);
                    end
                end
            end
            prev_pend = avm_write && avm_waitrequest;
            prev_addr = avm_address;
            prev_data = avm_writedata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int a, input logic [6:0] d);
        exp_q.push_back({3'(a), 25'b0, d});
    endtask

    // Called at #1 after a posedge with value_ready high; rc = cycle to pulse refresh (0 = none)
    task automatic send(input logic [23:0] v, input logic [5:0] m, input int exp_cycles, input int rc);
        int n;
        value_in    = v;
        blank_mask  = m;
        value_valid = 1'b1;
        @(posedge clk);
        #1;
        value_valid = 1'b0;
        value_in    = 24'hFFFFFF;
        blank_mask  = 6'h3F;
        n = 1;
        refresh = (rc == 1);
        check("ready_drop", 32'(value_ready), 32'd0);
        while (!value_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            refresh = (n == rc);
        end
        refresh = 1'b0;
        check("ready_cycle", 32'(n), 32'(exp_cycles));
        check("writes_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset       = 1'b1;
        value_in    = '0;
        blank_mask  = '0;
        value_valid = 1'b0;
        refresh     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", 32'(value_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_write", 32'(avm_write), 32'd0);
        check("rst_addr", 32'(avm_address), 32'd0);
        check("rst_data", avm_writedata, 32'd0);

        // Full rewrite
        push(0, 7'h12); push(1, 7'h19); push(2, 7'h30);
        push(3, 7'h24); push(4, 7'h79); push(5, 7'h40);
        send(24'h012345, 6'b000000, 13, 0);

        // Identical value: scan only
        send(24'h012345, 6'b000000, 7, 0);

        // Single changed digit, then a blanked digit
        push(0, 7'h0E);
        send(24'h01234F, 6'b000000, 1 + 5 + 2, 0);
        push(5, 7'h7F);
        send(24'h01234F, 6'b100000, 1 + 5 + 2, 0);

        // Three wait states on digit 2
        stall_addr = 2; stall_len = 3; stall_cnt = 0;
        for (int i = 0; i < 6; i++) push(i, 7'h78);
        send(24'h777777, 6'b000000, 16, 0);
        stall_addr = -1;

        // Refresh while idle forces a full rewrite
        refresh = 1'b1;
        @(posedge clk);
        #1;
        refresh = 1'b0;
        for (int i = 0; i < 6; i++) push(i, 7'h78);
        send(24'h777777, 6'b000000, 13, 0);

        // Refresh coincides with completion of digit 5 (write in cycle 7)
        push(5, 7'h00);
        send(24'h877777, 6'b000000, 8, 7);
        for (int i = 0; i < 5; i++) push(i, 7'h78);
        send(24'h877777, 6'b000000, 1 + 1 + 10, 0);

        // Reset while a write is stalled
        stall_addr = 0; stall_len = 1000; stall_cnt = 0;
        value_in    = 24'h123456;
        blank_mask  = '0;
        value_valid = 1'b1;
        @(posedge clk);
        #1;
        value_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("stalled_write", 32'(avm_write), 32'd1);
        check("stalled_addr", 32'(avm_address), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_write", 32'(avm_write), 32'd0);
        check("abort_ready", 32'(value_ready), 32'd1);
        check("abort_data", avm_writedata, 32'd0);
        reset = 1'b0;
        stall_addr = -1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) push(i, 7'h78);
        push(5, 7'h00);
        send(24'h877777, 6'b000000, 13, 0);

        // Letter digits, digit 0 unchanged
        push(1, 7'h06); push(2, 7'h21); push(3, 7'h46);
        push(4, 7'h03); push(5, 7'h08);
        send(24'hABCDE7, 6'b000000, 12, 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
